hvgen_param: RTL and testbench

Parametrised video timing generator for arcade cores; successor to the fixed 384x263 generator. Runs on the system clock with a pixel clock-enable, produces pixel position counters, blanking, active-low syncs and blanked RGB. Sits between the game core (`PH`/`PV`/`POUT`) and the arcade video/scaler stage. Screen position offsets are adjustable but never change the line or frame length.

---
 rtl/hvgen_param_if.sv | 33 +++
 rtl/hvgen_param.sv | 152 +++++++++++++++
 tb/tb_hvgen_param.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hvgen_param_if.sv
// Signal bundle between a game core and the hvgen_param timing generator.
// The core side drives the master modport; the generator implements the slave modport.
`timescale 1ns/1ps
interface hvgen_param_if #(
  parameter int RGB_W = 12,
  parameter int CW    = 9
);
  // No valid/ready handshake: ce_pix qualifies every transfer. On a clk_sys edge with
  // ce_pix high the generator samples hoffs/voffs/rgb_in and advances all outputs once.
  // With ce_pix low, every output holds and frame_start reads 0.
  logic             ce_pix;
  logic [4:0]       hoffs;
  logic [2:0]       voffs;
  logic [RGB_W-1:0] rgb_in;
  logic [CW-1:0]    hpos;
  logic [CW-1:0]    vpos;
  logic             hblank;
  logic             vblank;
  logic             hsync;
  logic             vsync;
  logic [RGB_W-1:0] rgb_out;
  logic             frame_start;

  modport master (
    output ce_pix, hoffs, voffs, rgb_in,
    input  hpos, vpos, hblank, vblank, hsync, vsync, rgb_out, frame_start
  );

  modport slave (
    input  ce_pix, hoffs, voffs, rgb_in,
    output hpos, vpos, hblank, vblank, hsync, vsync, rgb_out, frame_start
  );
endinterface

// File: rtl/hvgen_param.sv
// Parametrised arcade video timing generator: counters, blanking, active-low syncs, blanked RGB.
// Define HVGEN_CSYNC_EN to add a registered active-low composite sync output (csync).
`timescale 1ns/1ps
module hvgen_param #(
  parameter int RGB_W       = 12,
  parameter int CW          = 9,
  parameter int H_TOTAL     = 384,
  parameter int H_ACT_START = 24,
  parameter int H_ACT_END   = 264,
  parameter int V_TOTAL     = 263,
  parameter int V_ACT_END   = 224,
  parameter int HS_START    = 288,
  parameter int HS_WIDTH    = 32,
  parameter int VS_START    = 226,
  parameter int VS_WIDTH    = 6,
  parameter int HOFF_STEP   = 2,
  parameter int VOFF_STEP   = 4
) (
  input logic clk_sys,
  input logic reset,
  hvgen_param_if.slave vif
`ifdef HVGEN_CSYNC_EN
  ,
  output logic csync
`endif
);

  localparam int XW = CW + 4;

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_AS_CW = CW'(H_ACT_START);
  localparam logic [CW:0]   H_AS    = (CW+1)'(H_ACT_START);
  localparam logic [CW:0]   H_AE    = (CW+1)'(H_ACT_END);
  localparam logic [CW:0]   V_AE    = (CW+1)'(V_ACT_END);

  localparam logic [XW-1:0] H_TOT_X  = XW'(H_TOTAL);
  localparam logic [XW-1:0] V_TOT_X  = XW'(V_TOTAL);
  localparam logic [XW-1:0] HS_ST_X  = XW'(HS_START);
  localparam logic [XW-1:0] VS_ST_X  = XW'(VS_START);
  localparam logic [XW-1:0] HS_W_X   = XW'(HS_WIDTH);
  localparam logic [XW-1:0] VS_W_X   = XW'(VS_WIDTH);
  localparam logic [XW-1:0] HSTEP_X  = XW'(HOFF_STEP);
  localparam logic [XW-1:0] VSTEP_X  = XW'(VOFF_STEP);

  logic [CW-1:0]    hcnt_q, hcnt_d;
  logic [CW-1:0]    vcnt_q, vcnt_d;
  logic [4:0]       hoffs_l_q, hoffs_l_d;
  logic [2:0]       voffs_l_q, voffs_l_d;
  logic             hblank_q, hblank_d;
  logic             vblank_q, vblank_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             frame_start_q, frame_start_d;

  logic             h_wrap, v_wrap;
  logic [XW-1:0]    hs0_raw, hs0, vs0_raw, vs0;
  logic [XW-1:0]    hx, vx, hdist, vdist;

  always_comb begin
    h_wrap        = (hcnt_q == H_LAST);
    v_wrap        = (vcnt_q == V_LAST);
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    hoffs_l_d     = hoffs_l_q;
    voffs_l_d     = voffs_l_q;
    frame_start_d = 1'b0;

    if (vif.ce_pix) begin
      hcnt_d = h_wrap ? '0 : hcnt_q + 1'b1;
      if (h_wrap) begin
        vcnt_d = v_wrap ? '0 : vcnt_q + 1'b1;
      end
      if (h_wrap && v_wrap) begin
        frame_start_d = 1'b1;
        hoffs_l_d     = vif.hoffs;
        voffs_l_d     = vif.voffs;
      end
    end

    // Flags decode the next counter values with the offsets the next frame will use,
    // so the first pixel of a new frame already sees the freshly latched offsets.
    hs0_raw = HS_ST_X + XW'(hoffs_l_d) * HSTEP_X;
    hs0     = (hs0_raw >= H_TOT_X) ? hs0_raw - H_TOT_X : hs0_raw;
    vs0_raw = VS_ST_X + XW'(voffs_l_d) * VSTEP_X;
    vs0     = (vs0_raw >= V_TOT_X) ? vs0_raw - V_TOT_X : vs0_raw;

    hx    = XW'(hcnt_d);
    vx    = XW'(vcnt_d);
    hdist = (hx >= hs0) ? hx - hs0 : hx + H_TOT_X - hs0;
    vdist = (vx >= vs0) ? vx - vs0 : vx + V_TOT_X - vs0;

    hblank_d = !(({1'b0, hcnt_d} >= H_AS) && ({1'b0, hcnt_d} < H_AE));
    vblank_d = !({1'b0, vcnt_d} < V_AE);
    hsync_d  = !(hdist < HS_W_X);
    vsync_d  = (vif.ce_pix && h_wrap) ? !(vdist < VS_W_X) : vsync_q;
    rgb_d    = (hblank_q || vblank_q) ? '0 : vif.rgb_in;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      hoffs_l_q     <= '0;
      voffs_l_q     <= '0;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_start_d;
      if (vif.ce_pix) begin
        hcnt_q    <= hcnt_d;
        vcnt_q    <= vcnt_d;
        hoffs_l_q <= hoffs_l_d;
        voffs_l_q <= voffs_l_d;
        hblank_q  <= hblank_d;
        vblank_q  <= vblank_d;
        hsync_q   <= hsync_d;
        vsync_q   <= vsync_d;
        rgb_q     <= rgb_d;
      end
    end
  end

`ifdef HVGEN_CSYNC_EN
  logic csync_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      csync_q <= 1'b1;
    end else if (vif.ce_pix) begin
      csync_q <= hsync_d & vsync_d;
    end
  end

  assign csync = csync_q;
`endif

  assign vif.hpos        = hcnt_q - H_AS_CW;
  assign vif.vpos        = vcnt_q;
  assign vif.hblank      = hblank_q;
  assign vif.vblank      = vblank_q;
  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.rgb_out     = rgb_q;
  assign vif.frame_start = frame_start_q;

endmodule

// File: tb/tb_hvgen_param.sv
// Bench for hvgen_param: three instances (default hsync, HOFF_STEP=4, HS_START=370) on a
// 10-line frame, driven with irregular ce_pix and compared against a reference model.
`timescale 1ns/1ps
module tb_hvgen_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic [4:0]  hoffs;
  logic [2:0]  voffs;
  logic [11:0] rgb_in;

  int checks = 0;
  int errors = 0;

  hvgen_param_if #(.RGB_W(12), .CW(9)) ifa ();
  hvgen_param_if #(.RGB_W(12), .CW(9)) ifb ();
  hvgen_param_if #(.RGB_W(12), .CW(9)) ifc ();

  assign ifa.ce_pix = ce;  assign ifa.hoffs = hoffs;  assign ifa.voffs = voffs;  assign ifa.rgb_in = rgb_in;
  assign ifb.ce_pix = ce;  assign ifb.hoffs = hoffs;  assign ifb.voffs = voffs;  assign ifb.rgb_in = rgb_in;
  assign ifc.ce_pix = ce;  assign ifc.hoffs = hoffs;  assign ifc.voffs = voffs;  assign ifc.rgb_in = rgb_in;

`ifdef HVGEN_CSYNC_EN
  logic csync_a, csync_b, csync_c;
`endif

  hvgen_param #(.V_TOTAL(10), .V_ACT_END(7), .VS_START(8), .VS_WIDTH(2), .VOFF_STEP(1)) u_a (
    .clk_sys(clk), .reset(reset), .vif(ifa)
`ifdef HVGEN_CSYNC_EN
    , .csync(csync_a)
`endif
  );

  hvgen_param #(.V_TOTAL(10), .V_ACT_END(7), .VS_START(8), .VS_WIDTH(2), .VOFF_STEP(1),
                .HOFF_STEP(4)) u_b (
    .clk_sys(clk), .reset(reset), .vif(ifb)
`ifdef HVGEN_CSYNC_EN
    , .csync(csync_b)
`endif
  );

  hvgen_param #(.V_TOTAL(10), .V_ACT_END(7), .VS_START(8), .VS_WIDTH(2), .VOFF_STEP(1),
                .HS_START(370)) u_c (
    .clk_sys(clk), .reset(reset), .vif(ifc)
`ifdef HVGEN_CSYNC_EN
    , .csync(csync_c)
`endif
  );

  // clock
  always #5 clk = ~clk;

  // reference model state
  int          ref_h, ref_v, ref_hl, ref_vl, ref_frames, dut_frames;
  bit          post_ce;
  logic [11:0] rgb_exp;
  logic [11:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_hs(input int h, input int hs_start, input int step, input int hl);
    int hs0;
    hs0 = (hs_start + hl * step) % 384;
    return !(((h - hs0 + 384) % 384) < 32);
  endfunction

  function automatic logic exp_vs(input int v, input int vl);
    int vs0;
    vs0 = (8 + vl) % 10;
    return !(((v - vs0 + 10) % 10) < 2);
  endfunction

  function automatic logic model_blank();
    return !(ref_h >= 24 && ref_h < 264) || !(ref_v < 7);
  endfunction

  task automatic model_reset();
    ref_h = 0; ref_v = 0; ref_hl = 0; ref_vl = 0;
    post_ce = 1'b0;
    rgb_exp = '0;
    exp_q.delete();
  endtask

  task automatic compare_all(input logic fs);
    int he;
    he = (ref_h - 24) & 511;
    chk("a_hpos", 32'(ifa.hpos), 32'(he));
    chk("b_hpos", 32'(ifb.hpos), 32'(he));
    chk("c_hpos", 32'(ifc.hpos), 32'(he));
    chk("a_vpos", 32'(ifa.vpos), 32'(ref_v));
    chk("a_hblank", 32'(ifa.hblank), 32'(!(ref_h >= 24 && ref_h < 264)));
    chk("a_vblank", 32'(ifa.vblank), 32'(!(ref_v < 7)));
    chk("a_hsync", 32'(ifa.hsync), 32'(exp_hs(ref_h, 288, 2, ref_hl)));
    chk("b_hsync", 32'(ifb.hsync), 32'(exp_hs(ref_h, 288, 4, ref_hl)));
    if (post_ce) chk("c_hsync", 32'(ifc.hsync), 32'(exp_hs(ref_h, 370, 2, ref_hl)));
    chk("a_vsync", 32'(ifa.vsync), 32'(exp_vs(ref_v, ref_vl)));
    chk("c_vsync", 32'(ifc.vsync), 32'(exp_vs(ref_v, ref_vl)));
    chk("a_rgb_out", 32'(ifa.rgb_out), 32'(rgb_exp));
    chk("a_frame_start", 32'(ifa.frame_start), 32'(fs));
`ifdef HVGEN_CSYNC_EN
    chk("a_csync", 32'(csync_a), 32'(exp_hs(ref_h, 288, 2, ref_hl) & exp_vs(ref_v, ref_vl)));
    if (post_ce)
      chk("c_csync", 32'(csync_c), 32'(exp_hs(ref_h, 370, 2, ref_hl) & exp_vs(ref_v, ref_vl)));
`endif
    if (ifa.frame_start === 1'b1) dut_frames++;
  endtask

  task automatic dir_checks();
    if (ref_frames == 0 && ref_v == 0) begin
      if (ref_h == 23)  chk("hblank_at_23", 32'(ifa.hblank), 32'd1);
      if (ref_h == 24) begin
        chk("hpos_at_24", 32'(ifa.hpos), 32'd0);
        chk("hblank_at_24", 32'(ifa.hblank), 32'd0);
      end
      if (ref_h == 263) chk("hblank_at_263", 32'(ifa.hblank), 32'd0);
      if (ref_h == 264) chk("hblank_at_264", 32'(ifa.hblank), 32'd1);
      if (ref_h == 287) chk("a_hs_287", 32'(ifa.hsync), 32'd1);
      if (ref_h == 288) chk("a_hs_288", 32'(ifa.hsync), 32'd0);
      if (ref_h == 319) chk("a_hs_319", 32'(ifa.hsync), 32'd0);
      if (ref_h == 320) chk("a_hs_320", 32'(ifa.hsync), 32'd1);
      if (ref_h == 17)  chk("c_hs_17", 32'(ifc.hsync), 32'd0);
      if (ref_h == 18)  chk("c_hs_18", 32'(ifc.hsync), 32'd1);
      if (ref_h == 369) chk("c_hs_369", 32'(ifc.hsync), 32'd1);
      if (ref_h == 370) chk("c_hs_370", 32'(ifc.hsync), 32'd0);
      if (ref_h == 383) chk("c_hs_383", 32'(ifc.hsync), 32'd0);
    end
    if (ref_frames == 0 && ref_h == 0) begin
      if (ref_v == 6) chk("vblank_line6", 32'(ifa.vblank), 32'd0);
      if (ref_v == 7) chk("vblank_line7", 32'(ifa.vblank), 32'd1);
      if (ref_v == 7) chk("vsync_line7", 32'(ifa.vsync), 32'd1);
      if (ref_v == 8) chk("vsync_line8", 32'(ifa.vsync), 32'd0);
    end
    if (ref_frames == 1 && ref_v == 2) begin
      if (ref_h == 297) chk("a_hs5_297", 32'(ifa.hsync), 32'd1);
      if (ref_h == 298) chk("a_hs5_298", 32'(ifa.hsync), 32'd0);
      if (ref_h == 329) chk("a_hs5_329", 32'(ifa.hsync), 32'd0);
      if (ref_h == 330) chk("a_hs5_330", 32'(ifa.hsync), 32'd1);
    end
    if (ref_frames == 2 && ref_v == 2) begin
      if (ref_h == 27) chk("b_hs31_27", 32'(ifb.hsync), 32'd1);
      if (ref_h == 28) chk("b_hs31_28", 32'(ifb.hsync), 32'd0);
      if (ref_h == 59) chk("b_hs31_59", 32'(ifb.hsync), 32'd0);
      if (ref_h == 60) chk("b_hs31_60", 32'(ifb.hsync), 32'd1);
    end
  endtask

  // driver: random idle gap, then one ce_pix clock; called at #1 after a posedge
  task automatic do_ce();
    int  gap;
    bit  hw, vw;
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      ce = 1'b0;
      @(posedge clk); #1;
      compare_all(1'b0);
    end
    rgb_in = 12'($urandom_range(0, 4095));
    ce     = 1'b1;
    exp_q.push_back(model_blank() ? 12'h000 : rgb_in);
    @(posedge clk); #1;
    ce = 1'b0;
    hw = (ref_h == 383);
    vw = hw && (ref_v == 9);
    ref_h = hw ? 0 : ref_h + 1;
    if (hw) ref_v = vw ? 0 : ref_v + 1;
    if (vw) begin
      ref_hl = int'(hoffs);
      ref_vl = int'(voffs);
      ref_frames++;
    end
    post_ce = 1'b1;
    rgb_exp = exp_q.pop_front();
    compare_all(vw);
    dir_checks();
  endtask

  initial begin
    reset  = 1'b1;
    ce     = 1'b0;
    hoffs  = '0;
    voffs  = '0;
    rgb_in = '0;
    ref_frames = 0;
    dut_frames = 0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_hpos", 32'(ifa.hpos), 32'h1E8);
    chk("rst_vpos", 32'(ifa.vpos), 32'd0);
    chk("rst_hblank", 32'(ifa.hblank), 32'd1);
    chk("rst_vblank", 32'(ifa.vblank), 32'd0);
    chk("rst_hsync", 32'(ifa.hsync), 32'd1);
    chk("rst_vsync", 32'(ifa.vsync), 32'd1);
    chk("rst_rgb_out", 32'(ifa.rgb_out), 32'd0);
    chk("rst_frame_start", 32'(ifa.frame_start), 32'd0);
    reset = 1'b0;

    // frame 0 with zero offsets; change offsets mid-frame
    for (int n = 0; n < 1500; n++) do_ce();
    hoffs = 5'd5;
    voffs = 3'd2;
    for (int n = 0; n < 5000 && ref_frames < 1; n++) do_ce();
    for (int n = 0; n < 1500; n++) do_ce();
    hoffs = 5'd31;
    voffs = 3'd5;
    for (int n = 0; n < 8000 && ref_frames < 3; n++) do_ce();
    chk("frames_model", 32'(ref_frames), 32'd3);
    chk("frames_seen", 32'(dut_frames), 32'd3);

    // asynchronous reset mid-line
    for (int n = 0; n < 400 && ref_h != 150; n++) do_ce();
    chk("pre_reset_hpos", 32'(ifa.hpos), 32'd126);
    reset = 1'b1;
    ce    = 1'b1;
    #1;
    chk("mid_rst_hpos", 32'(ifa.hpos), 32'h1E8);
    chk("mid_rst_vpos", 32'(ifa.vpos), 32'd0);
    chk("mid_rst_hblank", 32'(ifa.hblank), 32'd1);
    chk("mid_rst_vblank", 32'(ifa.vblank), 32'd0);
    chk("mid_rst_hsync", 32'(ifa.hsync), 32'd1);
    chk("mid_rst_vsync", 32'(ifa.vsync), 32'd1);
    chk("mid_rst_rgb_out", 32'(ifa.rgb_out), 32'd0);
    chk("mid_rst_frame_start", 32'(ifa.frame_start), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_hpos", 32'(ifa.hpos), 32'h1E8);
    reset = 1'b0;
    ce    = 1'b0;
    model_reset();
    do_ce();
    chk("post_rst_hpos", 32'(ifa.hpos), 32'h1E9);
    for (int n = 0; n < 500; n++) do_ce();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
